mem_arbiter: RTL
================

// Module: mem_arbiter
//
// PURPOSE
// Two-requester round-robin arbiter and sequencer for the single-port 1024-entry
// synchronous memory (1-cycle registered read, write-enable + addr + data).
// After reset it sweeps every address to zero, then serves one access per cycle.
// Typical use: requester 0 = pixel/data writer, requester 1 = display reader.
//
// PARAMETERS
// DW        8   data width (8 for mem, 1 for mem_disp)
// AW        10  address width (depth = 2**AW = 1024)
// CLR_INIT  1   1: run clear sweep after reset; 0: go straight to RUN
//
// PORTS
// clk        in   1   system clock, all state on rising edge
// reset      in   1   asynchronous, active-high reset
// req0/req1  in   1   access request, held until matching gnt
// we0/we1    in   1   1 = write, 0 = read; stable while req high
// addr0/1    in   AW  access address; stable while req high
// wdata0/1   in   DW  write data; stable while req high
// gnt0/gnt1  out  1   combinational grant; access performed at this clock edge
// rvalid0/1  out  1   one-cycle pulse: read data for requester valid
// rdata      out  DW  read data (= mem_d_o), meaningful only with an rvalid
// busy       out  1   1 while clear sweep in progress
// mem_wr     out  1   to memory wr
// mem_addr   out  AW  to memory addr
// mem_d_i    out  DW  to memory d_i
// mem_d_o    in   DW  from memory d_o
//
// BEHAVIOUR
// - States: CLEAR, RUN. Reset -> CLEAR if CLR_INIT else RUN; clr_cnt=0, ptr=1,
//   rvalid0/1=0. gnt0/1=0, mem_wr=1 in CLEAR, busy=1 in CLEAR else 0.
// - CLEAR: each cycle mem_wr=1, mem_addr=clr_cnt, mem_d_i=0, clr_cnt++.
//   At clr_cnt==2**AW-1 the write occurs and the next state is RUN (exactly 2**AW
//   cycles; the counter does not wrap). No grants in CLEAR; requests simply wait.
// - RUN grant: only one req -> grant it. Both -> grant the one != ptr (ptr = last
//   granted). Neither -> no grant, mem_wr=0, mem_addr/mem_d_i hold last values.
// - ptr updates to the granted index at every granting edge; reset ptr=1 so
//   requester 0 wins the first tie.
// - Granted cycle: mem_wr=we_k, mem_addr=addr_k, mem_d_i=wdata_k (combinational mux).
// - Read latency: gnt on read at edge N -> rvalid_k=1 in cycle N+1, rdata=mem_d_o.
//   Writes never raise rvalid. Back-to-back accesses: 1 per cycle, no bubbles.
// - Read and write by different requesters in consecutive cycles to the same
//   address: read returns memory contents at its grant edge (write-first not
//   applicable; accesses are serialised).
// - Async reset mid-operation: in-flight rvalid dropped, state to CLEAR, sweep
//   restarts at address 0; memory contents not otherwise guaranteed.
// - Both rvalid never high together; gnt0 & gnt1 never high together.
//
// TESTING
// 1. Release reset -> busy high exactly 1024 cycles, mem_wr=1, mem_addr 0..1023,
//    mem_d_i=0; then req1 read addr 5 -> rvalid1 next cycle, rdata=8'h00.
// 2. req0 we=1 addr 10 wdata 8'hA5 -> gnt0 same cycle; then req1 read addr 10 ->
//    rvalid1 one cycle after gnt1, rdata=8'hA5.
// 3. req0 and req1 held high as reads for 6 cycles -> gnt 0,1,0,1,0,1; rvalids
//    follow 1 cycle later in the same order.
// 4. req0 asserted during CLEAR -> gnt0 stays 0 until busy falls, then gnt0 in
//    the first RUN cycle.
// 5. Assert reset the cycle after a read grant -> rvalid0 stays 0, busy=1,
//    mem_addr=0 on the first cycle after release.
// 6. Only req1 held for 4 writes (addr 0..3, data 1..4) -> 4 consecutive gnt1;
//    readback via req0 returns 1,2,3,4.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for a single-port synchronous memory.
// Zeroes every address after reset, then serves one access per cycle from two requesters.
module mem_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 10,
    parameter bit CLR_INIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d_i,
    input  logic [DW-1:0] mem_d_o,
    output logic          o_dbg_state
);

    // Handshake: a requester holds req (with we/addr/wdata stable) until it sees
    // gnt high; the access happens at the rising edge that ends that cycle.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_clr_cnt;
    logic          r_ptr;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [AW-1:0] r_hold_addr;
    logic [DW-1:0] r_hold_d;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_mem_wr;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLR_INIT ? ST_CLEAR : ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_addr   = r_hold_addr;
        w_mem_d      = r_hold_d;
        case (r_state)
            ST_CLEAR: begin
                w_mem_wr   = 1'b1;
                w_mem_addr = r_clr_cnt;
                w_mem_d    = '0;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // On a tie, the requester that did not win last time goes first.
                if (req0 && (!req1 || r_ptr)) begin
                    w_gnt0 = 1'b1;
                end else if (req1) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0) begin
                    w_mem_wr   = we0;
                    w_mem_addr = addr0;
                    w_mem_d    = wdata0;
                end else if (w_gnt1) begin
                    w_mem_wr   = we1;
                    w_mem_addr = addr1;
                    w_mem_d    = wdata1;
                end
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt   <= '0;
            r_ptr       <= 1'b1;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_hold_addr <= '0;
            r_hold_d    <= '0;
        end else begin
            // Counter parks at the last address rather than wrapping.
            if (r_state == ST_CLEAR && r_clr_cnt != LAST_ADDR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_gnt0) begin
                r_ptr <= 1'b0;
            end else if (w_gnt1) begin
                r_ptr <= 1'b1;
            end
            r_rvalid0   <= w_gnt0 & ~we0;
            r_rvalid1   <= w_gnt1 & ~we1;
            r_hold_addr <= w_mem_addr;
            r_hold_d    <= w_mem_d;
        end
    end

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata       = mem_d_o;
    assign busy        = (r_state == ST_CLEAR);
    assign mem_wr      = w_mem_wr;
    assign mem_addr    = w_mem_addr;
    assign mem_d_i     = w_mem_d;
    assign o_dbg_state = r_state;

endmodule
